// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester arbitrating mux: state encoding,
// default parameters and the hold counter width.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_MAX_HOLD = 4;
  // Wide enough for MAX_HOLD-1 with MAX_HOLD up to 15.
  localparam int HOLD_W           = 4;

endpackage

// File: rtl/mux_arb_dp.sv
// Registered data mux: captures the granted requester's word on a transfer
// cycle and flags it with x_valid one cycle later.
module mux_arb_dp
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             xfer,
  input  logic             sel_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic             x_valid
);

  // Output stage: x keeps its last word whenever no transfer happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      x_valid <= 1'b0;
    end else begin
      x_valid <= xfer;
      if (xfer) x <= sel_b ? b : a;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter with bounded hold time and a registered data mux.
// Ties go to the side that was not granted last; A wins the first tie.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] x,
  output logic             x_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state, state_nxt;
  logic              last_gnt, last_gnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              xfer;
  logic              at_limit;

  assign xfer     = ((state == GNT_A) && req_a) || ((state == GNT_B) && req_b);
  assign at_limit = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        if (req_a && req_b)  state_nxt = last_gnt ? GNT_A : GNT_B;
        else if (req_a)      state_nxt = GNT_A;
        else if (req_b)      state_nxt = GNT_B;
      end
      GNT_A: begin
        // A dropped request hands over immediately, even at the hold limit.
        if (!req_a)                state_nxt = req_b ? GNT_B : IDLE;
        else if (req_b && at_limit) state_nxt = GNT_B;
      end
      GNT_B: begin
        if (!req_b)                state_nxt = req_a ? GNT_A : IDLE;
        else if (req_a && at_limit) state_nxt = GNT_A;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) begin
      hold_cnt_nxt = '0;
      if (state_nxt == GNT_A) last_gnt_nxt = 1'b0;
      if (state_nxt == GNT_B) last_gnt_nxt = 1'b1;
    end else if (xfer) begin
      // Uncontested holder wraps the count instead of losing the grant.
      hold_cnt_nxt = at_limit ? '0 : hold_cnt + 1'b1;
    end
  end

  // Control registers; reset leaves B as last winner so A takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  assign gnt_a = (state == GNT_A);
  assign gnt_b = (state == GNT_B);
  assign sel   = gnt_b;

  mux_arb_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .xfer   (xfer),
    .sel_b  (gnt_b),
    .a      (a),
    .b      (b),
    .x      (x),
    .x_valid(x_valid)
  );

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed and randomized bench for mux_arbiter, compared each cycle
// against a behavioural owner/run-length model.
module tb_mux_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req_a = 1'b0, req_b = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             gnt_a, gnt_b, sel, x_valid;
  logic [WIDTH-1:0] x;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner 0 = nobody, 1 = A, 2 = B; run = transfers in current tenure mod MAX_HOLD.
  int               owner;
  int               run;
  bit               a_first;
  logic [WIDTH-1:0] exp_x;
  bit               exp_xv;

  mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .x(x), .x_valid(x_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; run = 0; a_first = 1'b1; exp_x = '0; exp_xv = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_gnt_a"},   gnt_a,   (owner == 1));
    chk({tag, "_gnt_b"},   gnt_b,   (owner == 2));
    chk({tag, "_sel"},     sel,     (owner == 2));
    chk({tag, "_x"},       x,       exp_x);
    chk({tag, "_x_valid"}, x_valid, exp_xv);
    chk({tag, "_hold"},    dut.hold_cnt, run);
    chk({tag, "_mutex"},   gnt_a & gnt_b, 1'b0);
    chk({tag, "_sel_gb"},  sel,     gnt_b);
  endtask

  // Advance one clock: predict from pre-edge inputs, then compare after the edge.
  task automatic step(input string tag);
    bit mine, other, moved, xfer;
    int nxt, opp;
    xfer = (owner == 1 && req_a) || (owner == 2 && req_b);
    if (owner == 0) begin
      if (req_a && req_b) nxt = a_first ? 1 : 2;
      else if (req_a)     nxt = 1;
      else if (req_b)     nxt = 2;
      else                nxt = 0;
    end else begin
      mine  = (owner == 1) ? req_a : req_b;
      other = (owner == 1) ? req_b : req_a;
      opp   = 3 - owner;
      if (!mine)                            nxt = other ? opp : 0;
      else if (other && run == MAX_HOLD-1)  nxt = opp;
      else                                  nxt = owner;
    end
    moved = (nxt != owner);
    @(posedge clk);
    #1;
    if (xfer) begin
      exp_x  = (owner == 1) ? a : b;
      exp_xv = 1'b1;
    end else begin
      exp_xv = 1'b0;
    end
    if (moved) begin
      run = 0;
      if (nxt == 1) a_first = 1'b0;
      if (nxt == 2) a_first = 1'b1;
    end else if (xfer) begin
      run = (run + 1) % MAX_HOLD;
    end
    owner = nxt;
    check_all(tag);
  endtask

  // Asserts reset between edges, checks outputs clear at once, releases after an edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_gnt_a"}, gnt_a, 1'b0);
    chk({tag, "_rst_gnt_b"}, gnt_b, 1'b0);
    chk({tag, "_rst_sel"},   sel,   1'b0);
    chk({tag, "_rst_x"},     x,     8'h00);
    chk({tag, "_rst_xv"},    x_valid, 1'b0);
    chk({tag, "_rst_hold"},  dut.hold_cnt, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset("init");

    // Single requester A.
    req_a = 1'b1; a = 8'h5A;
    step("single1");
    chk("single_gnt", gnt_a, 1'b1);
    step("single2");
    chk("single_x", x, 8'h5A);
    chk("single_xv", x_valid, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step("single_hold");
      chk("single_no_b", gnt_b, 1'b0);
    end
    req_a = 1'b0;
    step("single_drop");
    step("single_idle");

    // First tie after reset goes to A, then alternates every MAX_HOLD transfers.
    do_reset("tie");
    req_a = 1'b1; req_b = 1'b1; a = 8'h11; b = 8'h22;
    for (int i = 1; i <= 13; i++) begin
      step("tie");
      chk("tie_owner", gnt_b, ((i - 1) / MAX_HOLD) % 2 == 1);
    end
    req_a = 1'b0; req_b = 1'b0;
    step("tie_end");

    // Early release: A drops after two cycles with B waiting.
    do_reset("early");
    req_a = 1'b1; a = 8'h3C;
    step("early_a");
    step("early_a2");
    req_a = 1'b0; req_b = 1'b1; b = 8'hC3;
    step("early_sw");
    chk("early_gnt_b", gnt_b, 1'b1);
    step("early_x");
    chk("early_x_b", x, 8'hC3);
    req_b = 1'b0;
    step("early_end");

    // Hold wrap with A uncontested.
    do_reset("wrap");
    req_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 8'(i + 8'h40);
      step("wrap");
      chk("wrap_gnt_a", gnt_a, 1'b1);
    end
    req_a = 1'b0;
    step("wrap_end");

    // Mid-grant reset with B holding; A must win the tie afterwards.
    req_b = 1'b1; b = 8'h99;
    step("mid_b1");
    step("mid_b2");
    chk("mid_pre_gnt_b", gnt_b, 1'b1);
    req_a = 1'b1;
    do_reset("mid");
    step("mid_after");
    chk("mid_first_a", gnt_a, 1'b1);
    req_a = 1'b0; req_b = 1'b0;
    step("mid_end");

    // Randomized traffic, weighted towards requests being present.
    for (int i = 0; i < 400; i++) begin
      req_a = ($urandom_range(0, 3) != 0);
      req_b = ($urandom_range(0, 3) != 0);
      a = 8'($urandom);
      b = 8'($urandom);
      step("rand");
      if (i == 200) begin
        do_reset("rand_rst");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each input and of the output.
REQ-002 SHALL have parameter MAX_HOLD, default 4, maximum consecutive grant cycles while the other side waits; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_a / req_b  input  1  request from requester A / B.
REQ-006 SHALL have ports a / b  input  WIDTH  data from requester A / B.
REQ-007 SHALL have ports gnt_a / gnt_b  output  1  registered grant to A / B, never both high.
REQ-008 SHALL have port sel  output  1  registered select, 0 = A, 1 = B; equals gnt_b.
REQ-009 SHALL have port x  output  WIDTH  registered muxed data.
REQ-010 SHALL have port x_valid  output  1  x holds a transferred word.

Function
REQ-011 SHALL implement an FSM with states IDLE, GNT_A, GNT_B; gnt_a=1 only in GNT_A, gnt_b=1 only in GNT_B.
REQ-012 SHALL define a transfer as a cycle with gnt_X=1 and req_X=1.
REQ-013 SHALL, from IDLE, move next edge: to GNT_A if only req_a; to GNT_B if only req_b; to the side opposite last_gnt if both; otherwise stay in IDLE.
REQ-014 SHALL hold a 1-bit last_gnt, updated on every state entry to GNT_A (0) or GNT_B (1).
REQ-015 SHALL, in GNT_X with req_X=0, move to GNT_Y if req_Y=1, else to IDLE (no dead cycle on switch).
REQ-016 SHALL keep hold_cnt, cleared on every state change and incremented on each transfer cycle.
REQ-017 SHALL, in GNT_X with req_X=1, req_Y=1 and hold_cnt=MAX_HOLD-1, force a switch to GNT_Y next edge.
REQ-018 SHALL, when hold_cnt=MAX_HOLD-1 and req_Y=0, stay in GNT_X and wrap hold_cnt to 0.
REQ-019 SHALL register data with latency 1: on a transfer cycle, next edge x <= granted input and x_valid <= 1.
REQ-020 SHALL, otherwise, set x_valid to 0 next edge and hold x at its last value.
REQ-021 SHALL let a request dropped in the same cycle as a forced switch take the REQ-015 path.

Reset
REQ-022 SHALL, on rst_n=0, immediately force state=IDLE, last_gnt=1 (A wins first tie), hold_cnt=0, gnt_a=gnt_b=sel=0, x=0, x_valid=0.
REQ-023 SHALL, on reset mid-grant, drop the grant at once without completing the transfer, and resume arbitration on the first edge after rst_n=1.

Structure
REQ-024 SHALL place state encodings (IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2) and the default WIDTH/MAX_HOLD constants in shared package mux_arb_pkg.
REQ-025 SHALL split into FSM/counter logic in mux_arbiter and sub-module mux_arb_dp for the registered data mux and x_valid.

Verification
REQ-026 SHALL test single requester: req_a=1 held, a=8'h5A -> gnt_a=1 one edge later; x=8'h5A, x_valid=1 one edge after that; gnt_b never asserts.
REQ-027 SHALL test first tie after reset: req_a=req_b=1 together -> GNT_A first; after 4 transfers (MAX_HOLD=4) gnt_b=1 next edge, then alternation every 4 transfers.
REQ-028 SHALL test early release: A granted, req_a drops after 2 cycles with req_b=1 -> gnt_b=1 on the next edge with no IDLE cycle; x shows b data one edge later.
REQ-029 SHALL test hold wrap: only req_a for 10 cycles -> gnt_a stays 1 throughout and hold_cnt wraps 3->0 without a grant change.
REQ-030 SHALL test mid-grant reset: rst_n=0 while gnt_b=1 -> all outputs 0 immediately; with both requests then held, GNT_A is granted first after release.
REQ-031 SHALL check on every cycle that gnt_a and gnt_b are never both 1 and that sel equals gnt_b.
